// File: rtl/flit_activity_monitor.sv
// Flit activity monitor: splits a flit stream into packets on idle gaps and
// reports per-packet flit count, toggle sum and peak Hamming distance.
module flit_activity_monitor #(
    parameter int W        = 52,
    parameter int CNT_W    = 16,
    parameter int IDLE_GAP = 4,
    parameter int DROP_W   = 8,
    localparam int PK_W    = $clog2(W + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [W-1:0]      in_data,
    output logic              rpt_valid,
    input  logic              rpt_ready,
    output logic [CNT_W-1:0]  rpt_flits,
    output logic [CNT_W-1:0]  rpt_toggles,
    output logic [PK_W-1:0]   rpt_peak,
    output logic              rpt_sat,
    output logic [DROP_W-1:0] drop_cnt
);

    // state | meaning
    // IDLE  | no packet open; first valid flit opens one
    // RECV  | packet open; gap_cnt counts down idle cycles left before close
    typedef enum logic {IDLE, RECV} state_t;

    localparam int GAP_W = $clog2(IDLE_GAP + 1);
    localparam int SUM_W = ((CNT_W > PK_W) ? CNT_W : PK_W) + 1;
    localparam logic [SUM_W-1:0] CNT_MAX = {{(SUM_W-CNT_W){1'b0}}, {CNT_W{1'b1}}};

    state_t            state, state_nxt;
    logic [W-1:0]      prev_data;
    logic [CNT_W-1:0]  flits, toggles;
    logic [PK_W-1:0]   peak;
    logic              sat;
    logic [GAP_W-1:0]  gap_cnt;

    logic [W-1:0]      diff;
    logic [PK_W-1:0]   hd;
    logic              start, accum, close, space;
    logic [SUM_W-1:0]  flit_sum, tog_sum;
    logic [CNT_W-1:0]  flits_nxt, toggles_nxt;
    logic [PK_W-1:0]   peak_nxt;
    logic              sat_nxt;

    always_comb begin
        diff = in_data ^ prev_data;
        hd   = '0;
        for (int i = 0; i < W; i++) begin
            hd = hd + PK_W'(diff[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (in_valid) state_nxt = RECV;
            RECV: if (close)    state_nxt = IDLE;
            default:            state_nxt = IDLE;
        endcase
    end

    always_comb begin
        start = (state == IDLE) && in_valid;
        accum = (state == RECV) && in_valid;
        close = (state == RECV) && !in_valid && (gap_cnt == GAP_W'(1));
        space = !rpt_valid || rpt_ready;

        // A new packet starts from zero, so the same adders serve both cases.
        flit_sum = (start ? '0 : SUM_W'(flits)) + SUM_W'(1);
        tog_sum  = (start ? '0 : SUM_W'(toggles)) + SUM_W'(hd);

        flits_nxt   = (flit_sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : flit_sum[CNT_W-1:0];
        toggles_nxt = (tog_sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : tog_sum[CNT_W-1:0];
        peak_nxt    = (start || hd > peak) ? hd : peak;
        sat_nxt     = (!start && sat) || (flit_sum > CNT_MAX) || (tog_sum > CNT_MAX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_data <= '0;
            flits     <= '0;
            toggles   <= '0;
            peak      <= '0;
            sat       <= 1'b0;
            gap_cnt   <= '0;
        end else begin
            if (in_valid) begin
                prev_data <= in_data;
                flits     <= flits_nxt;
                toggles   <= toggles_nxt;
                peak      <= peak_nxt;
                sat       <= sat_nxt;
                gap_cnt   <= GAP_W'(IDLE_GAP);
            end else if (state == RECV) begin
                gap_cnt <= gap_cnt - GAP_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rpt_valid   <= 1'b0;
            rpt_flits   <= '0;
            rpt_toggles <= '0;
            rpt_peak    <= '0;
            rpt_sat     <= 1'b0;
            drop_cnt    <= '0;
        end else begin
            if (close && space) begin
                rpt_valid   <= 1'b1;
                rpt_flits   <= flits;
                rpt_toggles <= toggles;
                rpt_peak    <= peak;
                rpt_sat     <= sat;
            end else begin
                if (rpt_valid && rpt_ready) rpt_valid <= 1'b0;
                if (close && drop_cnt != '1) drop_cnt <= drop_cnt + DROP_W'(1);
            end
        end
    end

endmodule

// File: doc/flit_activity_monitor.md
# flit_activity_monitor

Receive-side counterpart to the flit injector used in datapath energy characterization. Observes a flit stream on a W-bit bus, infers packet boundaries from idle gaps, and accumulates per-packet flit count and bit-toggle activity (Hamming distance between consecutive valid flits). Completed packet statistics are offered on a single-entry valid/ready report port for collection by the bench or an on-chip logger.

## Interface
- W, 52, flit width in bits.
- CNT_W, 16, width of flit and toggle accumulators.
- IDLE_GAP, 4, consecutive idle cycles that close a packet (≥1).
- DROP_W, 8, width of dropped-report counter.

- clk  in  1  rising-edge clock, single clock domain.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  flit present this cycle.
- in_data  in  W  flit payload.
- rpt_valid  out  1  report register holds an unread report.
- rpt_ready  in  1  consumer accepts report.
- rpt_flits  out  CNT_W  flits in reported packet.
- rpt_toggles  out  CNT_W  sum of Hamming distances over reported packet.
- rpt_peak  out  clog2(W+1)  largest single-flit Hamming distance in packet.
- rpt_sat  out  1  a counter saturated during this packet.
- drop_cnt  out  DROP_W  reports lost to backpressure, saturating.

## Operation
- Hamming distance per valid flit: hd = popcount(in_data ^ prev_data). prev_data updates only on valid flits, persists across packets (bus holds value), resets to 0.
- FSM states IDLE, RECV.
  - IDLE: in_valid=1 → RECV; flits=1, toggles=hd, peak=hd, gap=0.
  - RECV, in_valid=1: flits+=1, toggles+=hd, peak=max(peak,hd), gap=0.
  - RECV, in_valid=0: gap+=1; when gap reaches IDLE_GAP → close packet, go IDLE.
  - Idle run shorter than IDLE_GAP does not split a packet.
- Accumulators saturate at 2^CNT_W−1; any saturation sets packet's sat flag.
- Close: if report register empty, or being drained this same cycle (rpt_valid & rpt_ready), load flits/toggles/peak/sat and set rpt_valid. Otherwise discard packet, drop_cnt+=1 (saturating).
- Report register held stable while rpt_valid=1 and rpt_ready=0. Transfer on rpt_valid & rpt_ready; rpt_valid clears unless a new close loads the same edge.
- rpt_ready ignored when rpt_valid=0.

## Timing
- Reset: rpt_valid=0, rpt_flits=0, rpt_toggles=0, rpt_peak=0, rpt_sat=0, drop_cnt=0, prev_data=0, FSM=IDLE, accumulators and gap cleared. Reset mid-packet discards the partial packet; no report.
- Last valid flit in cycle t; cycles t+1..t+IDLE_GAP idle; report loads on the edge ending cycle t+IDLE_GAP; rpt_valid=1 from cycle t+IDLE_GAP+1.
- in_valid in the first cycle after close starts a new packet in IDLE with no lost flit.
- Packet close and in_valid cannot coincide (close requires idle cycle).
- Throughput: one flit per cycle, no input backpressure; monitor never stalls the stream.
- Popcount and accumulate are single-cycle; no internal pipelining visible at ports.

## Test plan
- After reset, flits all-ones (52'hF_FFFF_FFFF_FFFF), 0, all-ones, then 4 idle → rpt_valid in 5th cycle after last flit; rpt_flits=3, rpt_toggles=156, rpt_peak=52, rpt_sat=0.
- Walking-fill flits 52'hFFC00_0000_0000, 52'hFFFFF_0000_0000, 3 idle, 52'hFFFFF_FFFC0_0000, then 4 idle → one report: flits=3, toggles=30, peak=10.
- rpt_ready=0; two 2-flit packets separated by 6 idle → first report held unchanged, drop_cnt=1; then rpt_ready=1 → one transfer, rpt_valid=0 next cycle.
- rpt_ready=1 exactly on the edge a second packet closes → first transferred, second loaded, rpt_valid stays 1, drop_cnt=0.
- Reset asserted one cycle after 5th flit of a packet → no report; next packet single flit 52'h3 → toggles=2 (prev_data back to 0).
- CNT_W=4: 20 back-to-back flits alternating 0/52'h1 → rpt_flits=15, rpt_toggles=15, rpt_sat=1.
